rs_packet_rx: RTL and testbench
===============================

// Module: rs_packet_rx
// PURPOSE
//  RS232 receiver with packet buffer. Upstream of the manager FSM.
//  Deserialises 8-bit frames from RXD and stores PKT_LEN bytes in a buffer.
//  When the packet is complete it asserts RS_DONE, then holds the packet for byte-wise readout toward flash.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per bit (50 MHz / 115200 baud)
//  PKT_LEN       16   bytes per packet; 2..2**AW
//  AW            4    buffer address width
// PORTS
//  CLK_50MHZ  in   1     system clock
//  RST        in   1     reset, synchronous, active-high
//  RXD        in   1     asynchronous serial line; idles high
//  RS_CLR     in   1     one-cycle pulse: release buffer, clear flags
//  RD_ADDR    in   AW    buffer read address
//  RD_DATA    out  8     buffer[RD_ADDR]; registered, 1-cycle latency
//  RS_DONE    out  1     level: packet complete, buffer frozen
//  BYTE_CNT   out  AW+1  bytes stored in the current packet
//  FRAME_ERR  out  1     sticky: stop bit sampled low
//  PAR_ERR    out  1     sticky: parity mismatch (tied 0 without PARITY_EN)
//  OVERRUN    out  1     sticky: byte arrived while RS_DONE=1
// BEHAVIOUR
//  - Reset values: RS_DONE, BYTE_CNT, FRAME_ERR, PAR_ERR, OVERRUN, RD_DATA all 0.
//  - Reset also: write pointer 0, bit FSM to IDLE; synchroniser regs reset to 1. Buffer RAM is not reset.
//  - RXD passes through a 2-FF synchroniser. All sampling uses the synchronised value.
//  - Bit FSM states: IDLE, START, DATA, PARITY, STOP.
//    - IDLE->START on a synchronised 1->0 edge. A low level present at reset release does not start a frame.
//    - START: wait CLKS_PER_BIT/2 cycles (217), then sample. Sample 1: false start, go to IDLE. Sample 0: go to DATA.
//    - DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first.
//    - DATA then STOP, or DATA then PARITY then STOP with the macro.
//    - STOP: sample at bit mid, then return to IDLE immediately, so back-to-back frames are accepted.
//    - byte_valid pulses 1 cycle after the stop sample when the stop bit is 1 and parity is OK.
//    - Stop bit 0: byte discarded, FRAME_ERR<=1.
//  - Packet logic, evaluated on each byte_valid:
//    - RS_DONE=0: write buf[wr_ptr], wr_ptr++, BYTE_CNT++. On the byte with BYTE_CNT reaching PKT_LEN, RS_DONE<=1 in the same cycle and wr_ptr<=0.
//    - RS_DONE=1: byte dropped, OVERRUN<=1, buffer unchanged.
//  - RS_CLR: next cycle RS_DONE, BYTE_CNT, wr_ptr and all sticky flags go to 0. The bit FSM is not disturbed.
//  - RS_CLR together with byte_valid: the packet restarts and the byte is stored at index 0, giving BYTE_CNT=1 and flags 0.
//  - RD_DATA <= buf[RD_ADDR] every cycle. Reads are legal at any time; content is meaningful only when RS_DONE=1.
//  - RD_ADDR >= PKT_LEN returns undefined data.
//  - RST mid-frame: the partial byte is lost and the next frame is received cleanly after reset.
// CONFIGURATION
//  - Macro RS_PARITY_EN defined: frame is 8E1, with an even-parity bit between data and stop.
//    - Mismatch: byte discarded, PAR_ERR<=1.
//    - Parity and framing errors on the same frame set both flags.
//  - Macro RS_PARITY_EN undefined: frame is 8N1, the PARITY state is not built, and PAR_ERR is constant 0.
// STRUCTURE
//  - Shared include rs_defs.vh holds:
//    - bit FSM state encodings (3-bit localparams);
//    - CLKS_PER_BIT_115200=434;
//    - default PKT_LEN.
//  - Sub-module uart_rx_byte owns the synchroniser and the bit FSM. Outputs: byte_valid, byte_data[7:0], frame_err_p, par_err_p.
//  - rs_packet_rx owns the buffer, wr_ptr, BYTE_CNT, RS_DONE, the flags and the read port.
// TESTING
//  1. 16 frames carrying 0x00..0x0F at 115200 8N1 -> RS_DONE=1 within 2 cycles after the 16th stop sample, BYTE_CNT=16. RD_ADDR=5 -> RD_DATA=0x05 the next cycle.
//  2. RXD low for 100 cycles, then high -> no byte_valid, BYTE_CNT=0, no flags set.
//  3. Frame 0xA5 with stop bit 0 -> FRAME_ERR=1, BYTE_CNT unchanged. The following good frame is stored normally.
//  4. 17th frame 0xFF while RS_DONE=1 -> OVERRUN=1, buf[0] unchanged. RS_CLR -> RS_DONE=0, BYTE_CNT=0, OVERRUN=0 on the next cycle.
//  5. RST pulsed mid-data of byte 3, then a full new packet -> BYTE_CNT counts from 0 and all 16 bytes read back correctly.
//  6. RS_PARITY_EN: byte 0x01 with parity bit 0 -> PAR_ERR=1, byte not stored. Parity bit 1 -> stored, PAR_ERR stays 0.

Source files
------------

// File: rtl/rs_packet_rx_pkg.sv
// Shared definitions for the RS232 packet receiver: bit-timing defaults,
// packet sizing defaults and the bit FSM state encoding.
package rs_packet_rx_pkg;

  localparam int unsigned CLKS_PER_BIT_115200 = 434;
  localparam int unsigned PKT_LEN_DEFAULT     = 16;
  localparam int unsigned AW_DEFAULT          = 4;
  localparam int unsigned DATA_BITS           = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte deserialiser: 2-FF synchroniser plus bit FSM, 8N1 by default,
// 8E1 when RS_PARITY_EN is defined.
module uart_rx_byte
  import rs_packet_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_p,
  output logic       par_err_p
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  logic            rx_s1, rx_s2, rx_prev;
  logic [1:0]      settle;
  logic            settled;
  rx_state_e       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            bit_end;
  logic            valid_n, ferr_n, perr_n;
  logic            par_bad;

  // Edge detection waits until rx_prev/rx_s2 both hold real line samples,
  // so a line already low at reset release is not mistaken for a start bit.
  assign settled   = (settle == 2'd3);
  assign bit_end   = (state == ST_START) ? (cnt == CW'(HALF - 1))
                                         : (cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_data = shreg;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (!settled) settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      frame_err_p <= 1'b0;
      par_err_p   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      byte_valid  <= valid_n;
      frame_err_p <= ferr_n;
      par_err_p   <= perr_n;
    end
  end

`ifdef RS_PARITY_EN
  logic par_bad_n;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) par_bad <= 1'b0;
    else     par_bad <= par_bad_n;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = bit_end ? '0 : cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
`ifdef RS_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (settled && rx_prev && !rx_s2) state_n = ST_START;
      end
      ST_START: begin
        if (bit_end) state_n = rx_s2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_n   = {rx_s2, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef RS_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef RS_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          par_bad_n = (^shreg) ^ rx_s2;
          state_n   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Return to IDLE right at the stop sample so the next start edge is caught.
        if (bit_end) begin
          state_n = ST_IDLE;
          ferr_n  = !rx_s2;
          perr_n  = par_bad;
          valid_n = rx_s2 && !par_bad;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/rs_packet_rx.sv
// RS232 receiver with a PKT_LEN-byte packet buffer frozen on completion for
// readout. Parity framing (8E1) is selected by defining RS_PARITY_EN.
module rs_packet_rx
  import rs_packet_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int unsigned PKT_LEN      = PKT_LEN_DEFAULT,
  parameter int unsigned AW           = AW_DEFAULT
) (
  input  logic          CLK_50MHZ,
  input  logic          RST,
  input  logic          RXD,
  input  logic          RS_CLR,
  input  logic [AW-1:0] RD_ADDR,
  output logic [7:0]    RD_DATA,
  output logic          RS_DONE,
  output logic [AW:0]   BYTE_CNT,
  output logic          FRAME_ERR,
  output logic          PAR_ERR,
  output logic          OVERRUN
);

  localparam int unsigned DEPTH = 1 << AW;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err_p, par_err_p;
  logic [AW-1:0] wr_ptr, wr_addr;
  logic          wr_en, last_byte;
  logic [7:0]    mem [DEPTH];

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK_50MHZ  (CLK_50MHZ),
    .RST        (RST),
    .rxd        (RXD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err_p(frame_err_p),
    .par_err_p  (par_err_p)
  );

  // A clear coinciding with a new byte restarts the packet with that byte at index 0.
  assign wr_en     = byte_valid && (RS_CLR || !RS_DONE);
  assign wr_addr   = RS_CLR ? '0 : wr_ptr;
  assign last_byte = (BYTE_CNT == (AW+1)'(PKT_LEN - 1));

  always_ff @(posedge CLK_50MHZ) begin
    if (wr_en) mem[wr_addr] <= byte_data;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      RD_DATA   <= '0;
      RS_DONE   <= 1'b0;
      BYTE_CNT  <= '0;
      wr_ptr    <= '0;
      FRAME_ERR <= 1'b0;
      PAR_ERR   <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      RD_DATA   <= mem[RD_ADDR];
      FRAME_ERR <= (FRAME_ERR && !RS_CLR) || frame_err_p;
      PAR_ERR   <= (PAR_ERR && !RS_CLR) || par_err_p;
      OVERRUN   <= (OVERRUN && !RS_CLR) || (byte_valid && RS_DONE && !RS_CLR);
      if (RS_CLR) begin
        RS_DONE  <= 1'b0;
        BYTE_CNT <= byte_valid ? (AW+1)'(1) : '0;
        wr_ptr   <= byte_valid ? AW'(1) : '0;
      end else if (byte_valid && !RS_DONE) begin
        BYTE_CNT <= BYTE_CNT + (AW+1)'(1);
        if (last_byte) begin
          RS_DONE <= 1'b1;
          wr_ptr  <= '0;
        end else begin
          wr_ptr  <= wr_ptr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_packet_rx.sv
// Self-checking bench for rs_packet_rx: constant vector table, directed
// multi-cycle corner cases and random frames against a queue-based packet model.
module tb_rs_packet_rx;

  localparam int unsigned CPB  = 40;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned PKT  = 16;
  localparam int unsigned AW   = 4;
`ifdef RS_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, rxd, rs_clr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rs_done, frame_err, par_err, overrun;
  logic [AW:0]   byte_cnt;

  rs_packet_rx #(.CLKS_PER_BIT(CPB), .PKT_LEN(PKT), .AW(AW)) dut (
    .CLK_50MHZ(clk),
    .RST      (rst),
    .RXD      (rxd),
    .RS_CLR   (rs_clr),
    .RD_ADDR  (rd_addr),
    .RD_DATA  (rd_data),
    .RS_DONE  (rs_done),
    .BYTE_CNT (byte_cnt),
    .FRAME_ERR(frame_err),
    .PAR_ERR  (par_err),
    .OVERRUN  (overrun)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packet model: stored bytes in a queue, flags as plain bits.
  logic [7:0] m_q[$];
  bit m_done, m_ferr, m_perr, m_ovr;

  function automatic void model_clr();
    m_q.delete();
    m_done = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit stop, input bit pb);
    bit bad_par;
    bad_par = PAR && pb;
    if (!stop) m_ferr = 1;
    if (bad_par) m_perr = 1;
    if (stop && !bad_par) begin
      if (m_done) m_ovr = 1;
      else begin
        m_q.push_back(d);
        if (m_q.size() == PKT) m_done = 1;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".cnt"},  32'(byte_cnt),  32'(m_q.size()));
    chk({tag, ".done"}, 32'(rs_done),   32'(m_done));
    chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".perr"}, 32'(par_err),   32'(m_perr));
    chk({tag, ".ovr"},  32'(overrun),   32'(m_ovr));
  endtask

  task automatic bit_time(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d, input bit pb);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PAR) bit_time(logic'((^d) ^ pb));
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pb);
    send_head(d, pb);
    bit_time(stop);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    rs_clr = 1'b1;
    @(negedge clk);
    rs_clr = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [7:0] d);
    rd_addr = AW'(addr);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".done"}, 32'(rs_done),   32'd0);
    chk({tag, ".cnt"},  32'(byte_cnt),  32'd0);
    chk({tag, ".ferr"}, 32'(frame_err), 32'd0);
    chk({tag, ".perr"}, 32'(par_err),   32'd0);
    chk({tag, ".ovr"},  32'(overrun),   32'd0);
    chk({tag, ".rd"},   32'(rd_data),   32'd0);
  endtask

  typedef struct {
    bit         clr;
    logic [7:0] data;
    bit         stop;
    bit         pb;
    int         exp_cnt;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[$];
    logic [7:0] d;
    logic [7:0] pkt[PKT];

    tbl.push_back('{1, 8'hA5, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 8'h3C, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 2, 1, 0});
    tbl.push_back('{1, 8'h7E, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 8'hFF, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 8'h81, 1, 0, 2, 1, 0});
`ifdef RS_PARITY_EN
    tbl.push_back('{1, 8'h01, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 8'h01, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 8'h02, 0, 1, 1, 1, 1});
`endif

    rst = 1'b1; rxd = 1'b1; rs_clr = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full packet 0x00..0x0F; RS_DONE timing checked around the last stop sample.
    for (int i = 0; i < 15; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_head(8'h0F, 1'b0);
    rxd = 1'b1;
    repeat (HALF + 1) @(negedge clk);
    chk("pkt.done_early", 32'(rs_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("pkt.done", 32'(rs_done), 32'd1);
    chk("pkt.cnt", 32'(byte_cnt), 32'd16);
    repeat (CPB - HALF - 4 + 4) @(negedge clk);
    rd(5, d);
    chk("pkt.rd5", 32'(d), 32'h05);

    // Overrun while frozen, then clear.
    send_frame(8'hFF, 1'b1, 1'b0);
    chk("ovr.flag", 32'(overrun), 32'd1);
    chk("ovr.cnt", 32'(byte_cnt), 32'd16);
    rd(0, d);
    chk("ovr.buf0", 32'(d), 32'h00);
    pulse_clr();
    chk("clr.done", 32'(rs_done), 32'd0);
    chk("clr.cnt", 32'(byte_cnt), 32'd0);
    chk("clr.ovr", 32'(overrun), 32'd0);

    // Short low glitch is a false start.
    rxd = 1'b0;
    repeat (HALF - 4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch.cnt", 32'(byte_cnt), 32'd0);
    chk("glitch.ferr", 32'(frame_err), 32'd0);
    chk("glitch.ovr", 32'(overrun), 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].clr) pulse_clr();
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].pb);
      chk($sformatf("tbl%0d.cnt", i), 32'(byte_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d.ferr", i), 32'(frame_err), 32'(tbl[i].exp_ferr));
      chk($sformatf("tbl%0d.perr", i), 32'(par_err), 32'(tbl[i].exp_perr));
    end

    // RS_CLR in the same cycle as byte_valid restarts the packet with that byte.
    send_frame(8'h11, 1'b0, 1'b0);
    send_head(8'h5A, 1'b0);
    rxd = 1'b1;
    repeat (HALF + 3) @(negedge clk);
    pulse_clr();
    chk("clrv.cnt", 32'(byte_cnt), 32'd1);
    chk("clrv.ferr", 32'(frame_err), 32'd0);
    chk("clrv.done", 32'(rs_done), 32'd0);
    repeat (CPB - HALF - 4 + 4) @(negedge clk);
    for (int i = 1; i < PKT; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("clrv.full", 32'(rs_done), 32'd1);
    rd(0, d);
    chk("clrv.buf0", 32'(d), 32'h5A);

    // Reset in the middle of data bit 2 of byte 3, line held low through release.
    pulse_clr();
    for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i), 1'b1, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    rxd = 1'b0;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (CPB - HALF - 2) @(negedge clk);
    for (int i = 3; i < 8; i++) bit_time(1'b0);
    bit_time(1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("rst_mid.cnt", 32'(byte_cnt), 32'd0);
    chk("rst_mid.ferr", 32'(frame_err), 32'd0);
    model_clr();
    for (int i = 0; i < PKT; i++) begin
      pkt[i] = 8'($urandom);
      send_frame(pkt[i], 1'b1, 1'b0);
      model_frame(pkt[i], 1'b1, 1'b0);
    end
    check_model("rst_pkt");
    for (int i = 0; i < PKT; i++) begin
      rd(i, d);
      chk($sformatf("rst_pkt.rd%0d", i), 32'(d), 32'(m_q[i]));
    end

    // Random frames with occasional framing/parity errors and clears.
    pulse_clr();
    model_clr();
    for (int k = 0; k < 60; k++) begin
      logic [7:0] rd8;
      bit stop, pb;
      if ($urandom_range(0, 11) == 0) begin
        pulse_clr();
        model_clr();
      end
      rd8  = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      pb   = ($urandom_range(0, 9) == 0);
      send_frame(rd8, stop, pb);
      model_frame(rd8, stop, pb);
      check_model($sformatf("rnd%0d", k));
      if (m_done && $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < PKT; i++) begin
          rd(i, d);
          chk($sformatf("rnd%0d.rd%0d", k, i), 32'(d), 32'(m_q[i]));
        end
        pulse_clr();
        model_clr();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
